// File: rtl/julia_pixel_engine.sv
// ---------------------------------------------------------------------------
// julia_pixel_engine
//
// Single-pixel Julia/Mandelbrot escape-time calculator. A task is accepted
// in IDLE, then z <- z^2 + c is iterated once per clock in signed fixed point
// (WIDTH bits, FRAC fractional bits) until |z|^2 >= 4.0 or the iteration
// count reaches the cap sampled at accept. The count is returned as the pixel
// value together with a flag that tells escape from cap termination.
//
// Optional feature: define JULIA_PIXEL_TAG_EN to add a TAG_BITS-wide tag
// that is latched at accept and returned next to the result, so a
// dispatcher can reorder results from several engines. Without the macro
// there are no tag ports and no tag register.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      task handshake (in_ready high only in IDLE)
//   mode                     0 = Julia, 1 = Mandelbrot
//   coord_real, coord_imag   signed pixel coordinate
//   c_real, c_imag           signed Julia constant (ignored when mode = 1)
//   max_iter                 iteration cap, sampled at accept
//   abort                    drop the task in flight (ignored in IDLE)
//   out_valid / out_ready    result handshake
//   pixel                    iteration count at termination
//   escaped                  1 = escape terminated, 0 = cap terminated
//   busy                     engine is not in IDLE
//   tag_in, tag_out          (JULIA_PIXEL_TAG_EN only) request/result tag
// ---------------------------------------------------------------------------
module julia_pixel_engine #(
  parameter int WIDTH     = 20,
  parameter int FRAC      = 10,
  parameter int ITER_BITS = 8
`ifdef JULIA_PIXEL_TAG_EN
  , parameter int TAG_BITS = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        mode,
  input  logic signed [WIDTH-1:0]     coord_real,
  input  logic signed [WIDTH-1:0]     coord_imag,
  input  logic signed [WIDTH-1:0]     c_real,
  input  logic signed [WIDTH-1:0]     c_imag,
  input  logic        [ITER_BITS-1:0] max_iter,
  input  logic                        abort,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [ITER_BITS-1:0] pixel,
  output logic                        escaped,
`ifdef JULIA_PIXEL_TAG_EN
  input  logic        [TAG_BITS-1:0]  tag_in,
  output logic        [TAG_BITS-1:0]  tag_out,
`endif
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // 4.0 in the squared-magnitude scale, which carries 2*FRAC fraction bits.
  localparam logic signed [2*WIDTH:0] ESC_LIMIT = (2*WIDTH+1)'(4) << (2*FRAC);

  state_t                     state;
  logic signed [WIDTH-1:0]    zr, zi, cr, ci;
  logic        [ITER_BITS-1:0] count, cap;

  logic signed [2*WIDTH-1:0]  zr_x, zi_x;
  logic signed [2*WIDTH-1:0]  rr, ii, rz;
  logic signed [2*WIDTH:0]    mag;
  logic signed [WIDTH-1:0]    zr_next, zi_next;

  // Full-precision squares and cross product. Operands are sign-extended to
  // 2*WIDTH first so the products are exact.
  always_comb begin
    zr_x = {{WIDTH{zr[WIDTH-1]}}, zr};
    zi_x = {{WIDTH{zi[WIDTH-1]}}, zi};
    rr   = zr_x * zr_x;
    ii   = zi_x * zi_x;
    rz   = zr_x * zi_x;
    mag  = {rr[2*WIDTH-1], rr} + {ii[2*WIDTH-1], ii};
    // Only bits [FRAC+WIDTH-1:FRAC] survive the truncation, so a wrap in the
    // top bit of rz <<< 1 (both operands at the most negative value) cannot
    // corrupt the kept bits.
    zr_next = WIDTH'((rr - ii) >>> FRAC) + cr;
    zi_next = WIDTH'((rz <<< 1) >>> FRAC) + ci;
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Main FSM. Abort outranks every state transition except reset; in IDLE
  // abort has nothing to drop and is ignored. pixel and escaped keep their
  // last result after the handoff and are only cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      zr        <= '0;
      zi        <= '0;
      cr        <= '0;
      ci        <= '0;
      count     <= '0;
      cap       <= '0;
      pixel     <= '0;
      escaped   <= 1'b0;
      out_valid <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mode) begin
              zr <= '0;
              zi <= '0;
              cr <= coord_real;
              ci <= coord_imag;
            end else begin
              zr <= coord_real;
              zi <= coord_imag;
              cr <= c_real;
              ci <= c_imag;
            end
            count <= '0;
            cap   <= max_iter;
            state <= ITER;
          end
        end
        ITER: begin
          if (mag >= ESC_LIMIT) begin
            pixel     <= count;
            escaped   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (count == cap) begin
            pixel     <= count;
            escaped   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            zr    <= zr_next;
            zi    <= zi_next;
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef JULIA_PIXEL_TAG_EN
  // The tag is captured with the task and simply held until the next
  // accept, which keeps it stable for the whole time out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_out <= '0;
    end else if ((state == IDLE) && in_valid) begin
      tag_out <= tag_in;
    end
  end
`else
  // No tag storage in this build; results are returned in request order.
`endif

endmodule

// File: doc/julia_pixel_engine.md
Name: julia_pixel_engine

Overview:
- Parametrised successor to the single-pixel calculator used in Julia_Worker.
- Iterates z <- z^2 + c in signed fixed point until the point escapes (|z|^2 >= 4.0) or a runtime iteration cap is reached, then returns the iteration count as the pixel value.
- Generalised in width, fraction bits and iteration-count width; adds a Julia/Mandelbrot mode, valid/ready handshakes on both sides, and abort.
- Sits between the work dispatcher and the pixel writeback buffer. One pixel in flight at a time.

Parameters:
- WIDTH, 20, total signed fixed-point width of every z/c operand.
- FRAC, 10, fractional bits (1.0 = 2^FRAC).
- ITER_BITS, 8, width of the iteration counter, max_iter and pixel.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  task request.
- in_ready  out  1  engine can accept a task (IDLE only).
- mode  in  1  0 = Julia, 1 = Mandelbrot.
- coord_real  in  WIDTH  signed pixel coordinate, real part.
- coord_imag  in  WIDTH  signed pixel coordinate, imaginary part.
- c_real  in  WIDTH  signed Julia constant, real part (ignored when mode=1).
- c_imag  in  WIDTH  signed Julia constant, imaginary part (ignored when mode=1).
- max_iter  in  ITER_BITS  iteration cap, sampled at accept.
- abort  in  1  drop the current task.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- pixel  out  ITER_BITS  iteration count at termination.
- escaped  out  1  1 = escape terminated the task, 0 = cap terminated it.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - out_valid=0, pixel=0, escaped=0, busy=0, in_ready=1.
  - Internal z, c and count are cleared.
- States: IDLE -> ITER -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch the task:
    - mode=0: z=coord, c=(c_real, c_imag).
    - mode=1: z=0, c=coord.
    - Also: count=0, cap=max_iter. Next state ITER.
- ITER, one iteration per cycle:
  - Compute rr=zr*zr and ii=zi*zi at full 2*WIDTH signed precision. mag=rr+ii at 2*WIDTH+1 bits.
  - If mag >= (4 << 2*FRAC): latch pixel=count, escaped=1, go to DONE.
  - Else if count == cap: latch pixel=count, escaped=0, go to DONE.
  - Else:
    - zr <= ((rr-ii) >>> FRAC) + cr.
    - zi <= ((2*zr*zi) >>> FRAC) + ci.
    - Both results are truncated to WIDTH bits (two's-complement wrap, no saturation). count <= count+1.
  - The escape check takes priority over the cap check when both are true in the same cycle.
- DONE:
  - out_valid=1. pixel and escaped are held stable until out_ready=1.
  - On out_ready, go to IDLE. in_ready rises the following cycle.
  - No new task is accepted in the handoff cycle.
- Latency:
  - Accept at cycle T gives out_valid at T+pixel+2.
  - Immediate escape gives T+2.
  - max_iter=0 gives pixel=0, escaped set per the escape test, at T+2.
- Abort (any state except IDLE): next cycle state=IDLE, out_valid=0, result discarded. Abort in IDLE is ignored.
- Reset mid-operation behaves the same as abort, plus all outputs clear.
- Inputs other than out_ready/abort are don't-care outside the accept cycle.

Optional Feature:
- Macro: JULIA_PIXEL_TAG_EN.
- Defined:
  - Adds parameter TAG_BITS (default 16).
  - Adds port tag_in (in, TAG_BITS), latched at accept.
  - Adds port tag_out (out, TAG_BITS), valid with out_valid and held alongside pixel.
  - Reset value of tag_out is 0.
  - Lets the dispatcher reorder results from multiple engines.
- Undefined: no tag ports and no tag register. All other behaviour is identical.

Test Plan:
All cases use WIDTH=20, FRAC=10, ITER_BITS=8; 1.0 = 1024.
1. Julia, coord=(0,0), c=(0,0), max_iter=255, out_ready=1 -> out_valid at T+257, pixel=255, escaped=0.
2. Julia, coord=(2048,0), c=(0,0), max_iter=255 -> out_valid at T+2, pixel=0, escaped=1.
3. Mandelbrot, coord=(1024,0) -> z: 0, 1.0, 2.0; escape at count 2; out_valid at T+4, pixel=2, escaped=1.
4. Case 2 with out_ready held low 5 cycles -> out_valid, pixel=0 and in_ready=0 held; in_ready=1 one cycle after the out_ready handshake; a back-to-back in_valid is accepted only then.
5. Case 1 with abort pulsed at T+10 -> out_valid never asserts, in_ready=1 at T+11; next task (case 2) completes normally with pixel=0.
6. Case 1 with rst pulsed at T+50 -> all outputs at reset values the next cycle, state IDLE; max_iter=0 task then gives pixel=0, escaped=0 at T'+2.
